// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS MEM stage (stage_mem and mem_access_fsm).
package mips_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Bit positions inside the 2-bit write-back control field.
  localparam int WBI_REGWRITE = 1;
  localparam int WBI_MEMTOREG = 0;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/stage_mem_access_fsm.sv
// Data-memory req/ack handshake with a wait-state timeout; reports stall, done and abort.
module mem_access_fsm
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic acc_i,
  input  logic ack_i,
  output logic req_o,
  output logic stall_o,
  output logic done_o,
  output logic abort_o
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req, done, abort;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        req = acc_i;
        if (acc_i && ack_i) begin
          done = 1'b1;
        end else if (acc_i) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        req = 1'b1;
        if (ack_i) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          abort   = 1'b1;
          req     = 1'b0;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Gating with reset makes mem_req fall the instant reset asserts, even with acc still high.
  assign req_o   = req & reset;
  assign stall_o = acc_i & ~ack_i & ~abort & reset;
  assign done_o  = done;
  assign abort_o = abort;

endmodule

// File: rtl/stage_mem.sv
// MIPS MEM stage: branch resolution, word load/store handshake and the MEM/WB register.
// Optional macro MEM_ALIGN_CHECK_EN suppresses misaligned accesses and adds misalign_o.
module stage_mem
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [31:0] data_b_in,
  input  logic [1:0]  wbi_in,
  input  logic        M_in,
  input  logic [4:0]  regaddr_in,
  input  logic        zero_in,
  input  logic        is_jump_in,
  input  logic        branch_eq_in,
  input  logic        branch_inc_in,
  input  logic [31:0] jump_address_in,
  output logic        pc_src_o,
  output logic [31:0] branch_target_o,
  output logic        stall_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  wbi_o,
  output logic [4:0]  regaddr_o,
  output logic [31:0] alu_o,
  output logic [31:0] mem_data_o,
  output logic        bus_err_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  logic        acc_raw, acc, misalign, is_load;
  logic        stall, done, abort;
  logic [1:0]  wbi_wr;

  logic [1:0]  wbi_q, wbi_d;
  logic [4:0]  regaddr_q, regaddr_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;

  assign pc_src_o        = is_jump_in | (branch_eq_in & zero_in) | (branch_inc_in & ~zero_in);
  assign branch_target_o = jump_address_in;

  assign acc_raw = M_in | (wbi_in[WBI_REGWRITE] & wbi_in[WBI_MEMTOREG]);
  assign is_load = ~M_in & wbi_in[WBI_REGWRITE] & wbi_in[WBI_MEMTOREG];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = acc_raw & (alu_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign acc = acc_raw & ~misalign;

  // A store wins over a load-looking wbi and must never write the register file.
  always_comb begin
    wbi_wr = wbi_in;
    if (M_in) wbi_wr[WBI_REGWRITE] = 1'b0;
  end

  mem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_fsm (
    .clock  (clock),
    .reset  (reset),
    .acc_i  (acc),
    .ack_i  (mem_ack),
    .req_o  (mem_req),
    .stall_o(stall),
    .done_o (done),
    .abort_o(abort)
  );

  assign stall_o   = stall;
  assign mem_we    = M_in & mem_req;
  assign mem_addr  = alu_in;
  assign mem_wdata = data_b_in;

  always_comb begin
    wbi_d      = wbi_q;
    regaddr_d  = regaddr_q;
    alu_d      = alu_q;
    mem_data_d = mem_data_q;
    bus_err_d  = bus_err_q;
    misalign_d = misalign;
    if (abort) begin
      wbi_d      = 2'b00;
      mem_data_d = '0;
      bus_err_d  = 1'b1;
    end else if (stall) begin
      wbi_d = 2'b00;
    end else begin
      wbi_d     = misalign ? 2'b00 : wbi_wr;
      regaddr_d = regaddr_in;
      alu_d     = alu_in;
      if (done && is_load) mem_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wbi_q      <= '0;
      regaddr_q  <= '0;
      alu_q      <= '0;
      mem_data_q <= '0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      wbi_q      <= wbi_d;
      regaddr_q  <= regaddr_d;
      alu_q      <= alu_d;
      mem_data_q <= mem_data_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  assign wbi_o      = wbi_q;
  assign regaddr_o  = regaddr_q;
  assign alu_o      = alu_q;
  assign mem_data_o = mem_data_q;
  assign bus_err_o  = bus_err_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_o = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem with a cycle-level reference model and per-cycle compare.
module tb_stage_mem;
  localparam int T = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] alu_in, data_b_in, jump_address_in, mem_rdata;
  logic [1:0]  wbi_in;
  logic        M_in, zero_in, is_jump_in, branch_eq_in, branch_inc_in, mem_ack;
  logic [4:0]  regaddr_in;
  logic        pc_src_o, stall_o, mem_req, mem_we, bus_err_o;
  logic [31:0] branch_target_o, mem_addr, mem_wdata, alu_o, mem_data_o;
  logic [1:0]  wbi_o;
  logic [4:0]  regaddr_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
  logic        m_mis;
`endif

  stage_mem dut (
    .clock(clock), .reset(reset), .alu_in(alu_in), .data_b_in(data_b_in),
    .wbi_in(wbi_in), .M_in(M_in), .regaddr_in(regaddr_in), .zero_in(zero_in),
    .is_jump_in(is_jump_in), .branch_eq_in(branch_eq_in), .branch_inc_in(branch_inc_in),
    .jump_address_in(jump_address_in), .pc_src_o(pc_src_o), .branch_target_o(branch_target_o),
    .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wbi_o(wbi_o),
    .regaddr_o(regaddr_o), .alu_o(alu_o), .mem_data_o(mem_data_o), .bus_err_o(bus_err_o)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int stall_cycles = 0;
  logic cmp_en = 1'b0;

  logic [1:0]  m_wbi;
  logic [4:0]  m_reg;
  logic [31:0] m_alu, m_data;
  logic        m_err;
  int          waited;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic misaligned_f();
`ifdef MEM_ALIGN_CHECK_EN
    return (M_in || wbi_in == 2'b11) && (alu_in[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic acc_f();
    return (M_in || wbi_in == 2'b11) && !misaligned_f();
  endfunction

  function automatic logic abort_f();
    return acc_f() && !mem_ack && waited == T;
  endfunction

  function automatic logic stall_f();
    return acc_f() && !mem_ack && !abort_f();
  endfunction

  // Reference model: "waited" is how many cycles the current access has already stalled.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_wbi <= '0; m_reg <= '0; m_alu <= '0; m_data <= '0; m_err <= 1'b0; waited <= 0;
`ifdef MEM_ALIGN_CHECK_EN
      m_mis <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      m_mis <= misaligned_f();
`endif
      if (abort_f()) begin
        m_wbi <= 2'b00; m_data <= '0; m_err <= 1'b1; waited <= 0;
      end else if (stall_f()) begin
        m_wbi <= 2'b00; waited <= waited + 1;
      end else begin
        if (misaligned_f()) m_wbi <= 2'b00;
        else if (M_in)      m_wbi <= {1'b0, wbi_in[0]};
        else                m_wbi <= wbi_in;
        m_reg <= regaddr_in;
        m_alu <= alu_in;
        if (!M_in && wbi_in == 2'b11 && mem_ack) m_data <= mem_rdata;
        waited <= 0;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      if (!reset) begin
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_wbi", {30'd0, wbi_o}, 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        chk("rst_err", {31'd0, bus_err_o}, 32'd0);
      end else begin
        chk("pc_src", {31'd0, pc_src_o},
            {31'd0, is_jump_in || (branch_eq_in && zero_in) || (branch_inc_in && !zero_in)});
        chk("target", branch_target_o, jump_address_in);
        chk("mem_req", {31'd0, mem_req}, {31'd0, acc_f() && !abort_f()});
        chk("stall", {31'd0, stall_o}, {31'd0, stall_f()});
        if (mem_req) begin
          chk("mem_we", {31'd0, mem_we}, {31'd0, M_in});
          chk("mem_addr", mem_addr, alu_in);
          chk("mem_wdata", mem_wdata, data_b_in);
        end
        chk("wbi_o", {30'd0, wbi_o}, {30'd0, m_wbi});
        chk("regaddr_o", {27'd0, regaddr_o}, {27'd0, m_reg});
        chk("alu_o", alu_o, m_alu);
        chk("mem_data_o", mem_data_o, m_data);
        chk("bus_err_o", {31'd0, bus_err_o}, {31'd0, m_err});
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_o", {31'd0, misalign_o}, {31'd0, m_mis});
`endif
        req_cycles   += int'(mem_req);
        stall_cycles += int'(stall_o);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic bubble();
    alu_in = 32'd0; data_b_in = 32'd0; wbi_in = 2'b00; M_in = 1'b0; regaddr_in = 5'd0;
    zero_in = 1'b0; is_jump_in = 1'b0; branch_eq_in = 1'b0; branch_inc_in = 1'b0;
    jump_address_in = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic drive(input logic [1:0] wbi, input logic m, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r);
    wbi_in = wbi; M_in = m; alu_in = a; data_b_in = d; regaddr_in = r;
  endtask

  initial begin
    bubble();
    #3;
    chk("reset_wbi", {30'd0, wbi_o}, 32'd0);
    chk("reset_req", {31'd0, mem_req}, 32'd0);
    cmp_en = 1'b1;
    #20 reset = 1'b1;
    step();

    // Branch resolution
    branch_eq_in = 1'b1; zero_in = 1'b1; jump_address_in = 32'h40; #1;
    chk("beq_taken", {31'd0, pc_src_o}, 32'd1);
    chk("beq_target", branch_target_o, 32'h40);
    step();
    branch_eq_in = 1'b0; branch_inc_in = 1'b1; zero_in = 1'b1; #1;
    chk("bne_not_taken", {31'd0, pc_src_o}, 32'd0);
    zero_in = 1'b0; #1;
    chk("bne_taken", {31'd0, pc_src_o}, 32'd1);
    step();
    bubble(); is_jump_in = 1'b1; jump_address_in = 32'h1234; #1;
    chk("jump_taken", {31'd0, pc_src_o}, 32'd1);
    step();
    bubble();
    step();

    // Zero-wait load
    req_cycles = 0; stall_cycles = 0;
    drive(2'b11, 1'b0, 32'h100, 32'h0, 5'd5); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    bubble();
    chk("zw_data", mem_data_o, 32'hDEADBEEF);
    chk("zw_wbi", {30'd0, wbi_o}, 32'd3);
    chk("zw_reg", {27'd0, regaddr_o}, 32'd5);
    chk("zw_stall_cycles", stall_cycles, 32'd0);
    step();
    chk("data_holds", mem_data_o, 32'hDEADBEEF);

    // Store with three wait states; wbi=11 is still a store
    req_cycles = 0; stall_cycles = 0;
    drive(2'b11, 1'b1, 32'h20, 32'h55, 5'd7);
    step();
    chk("st_bubble", {30'd0, wbi_o}, 32'd0);
    step(); step();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    bubble();
    chk("st_wbi", {30'd0, wbi_o}, 32'd1);
    chk("st_req_cycles", req_cycles, 32'd4);
    chk("st_stall_cycles", stall_cycles, 32'd3);
    chk("st_no_load", mem_data_o, 32'hDEADBEEF);
    step();

    // Timeout: ack never arrives
    req_cycles = 0; stall_cycles = 0;
    drive(2'b11, 1'b0, 32'h200, 32'h0, 5'd9);
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_err_o) break;
    end
    bubble();
    chk("to_err", {31'd0, bus_err_o}, 32'd1);
    chk("to_wbi", {30'd0, wbi_o}, 32'd0);
    chk("to_data", mem_data_o, 32'd0);
    chk("to_req_cycles", req_cycles, 32'd16);
    chk("to_stall_cycles", stall_cycles, 32'd16);
    step(); step();
    chk("to_sticky", {31'd0, bus_err_o}, 32'd1);

    // Plain ALU write-back
    drive(2'b10, 1'b0, 32'hABC, 32'h0, 5'd3);
    step();
    bubble();
    chk("alu_wbi", {30'd0, wbi_o}, 32'd2);
    chk("alu_val", alu_o, 32'hABC);

    // Reset on the second wait cycle
    drive(2'b11, 1'b0, 32'h300, 32'h0, 5'd4);
    step(); step();
    #1 reset = 1'b0;
    #1;
    chk("mr_req", {31'd0, mem_req}, 32'd0);
    chk("mr_wbi", {30'd0, wbi_o}, 32'd0);
    chk("mr_err", {31'd0, bus_err_o}, 32'd0);
    chk("mr_alu", alu_o, 32'd0);
    bubble();
    @(negedge clock);
    #2 reset = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    step();
    chk("late_ack_wbi", {30'd0, wbi_o}, 32'd0);
    chk("late_ack_data", mem_data_o, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    req_cycles = 0; stall_cycles = 0;
    drive(2'b11, 1'b0, 32'h102, 32'h0, 5'd6); mem_ack = 1'b0;
    step();
    bubble();
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_wbi", {30'd0, wbi_o}, 32'd0);
    chk("mis_req_cycles", req_cycles, 32'd0);
    step();
    chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
`endif

    step();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
